// File: rtl/wdt_pkg.sv
// Purpose: shared register map, CONTROL bit positions and FSM encoding for the watchdog.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wdt_pkg;

    localparam logic [2:0] WDT_ADDR_STATUS  = 3'd0;
    localparam logic [2:0] WDT_ADDR_CONTROL = 3'd1;
    localparam logic [2:0] WDT_ADDR_PERIODL = 3'd2;
    localparam logic [2:0] WDT_ADDR_PERIODH = 3'd3;
    localparam logic [2:0] WDT_ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] WDT_ADDR_SNAPH   = 3'd5;
    localparam logic [2:0] WDT_ADDR_KICK    = 3'd6;

    localparam int WDT_CTRL_ITO   = 0;
    localparam int WDT_CTRL_START = 2;
    localparam int WDT_CTRL_STOP  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WARN = 2'd2,
        ST_RST  = 2'd3
    } wdt_state_t;

endpackage

// File: rtl/wdt_down_counter.sv
// Purpose: CNT_W-bit down-counter with synchronous load (priority) and count enable, plus zero flag.
// Latency: load/decrement visible one clock after the request; zero flag is combinational from the count.
// Backpressure: none; load and enable are sampled every cycle.
module wdt_down_counter #(
    parameter int               CNT_W   = 32,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load beats decrement, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/wdt_timer_param.sv
// Purpose: 16-bit Avalon-MM two-stage watchdog (irq on first expiry, resetrequest pulse on second); WDT_LOCK_EN adds a sticky START lock.
// Latency: reads 1 clock; writes act on the strobe edge, counter effects of kick/period writes one clock later.
// Backpressure: none; the slave accepts every access with zero wait states.
module wdt_timer_param
    import wdt_pkg::*;
#(
    parameter int          CNT_W        = 32,
    parameter logic [31:0] RESET_PERIOD = 32'h004C_4B3F,
    parameter int          RST_CYCLES   = 4,
    parameter logic [15:0] KICK_KEY     = 16'hA5C3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    output logic        resetrequest
);

    localparam logic [CNT_W-1:0] RST_VAL = RESET_PERIOD[CNT_W-1:0];
    localparam int               RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    wdt_state_t       state_q;
    logic             to_q;
    logic             ito_q;
    logic             resetrequest_q;
    logic [RC_W-1:0]  rst_cnt_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] snap_q;
    logic             force_q;
    logic             kick_q;
    logic [15:0]      readdata_q;
    logic [15:0]      readdata_d;

    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             lock;

    // Access decode.
    logic wr, rd, wr_status, wr_ctrl, wr_perl, wr_perh, wr_snap, wr_kick;
    assign wr        = chipselect & ~write_n;
    assign rd        = chipselect & write_n;
    assign wr_status = wr && (address == WDT_ADDR_STATUS);
    assign wr_ctrl   = wr && (address == WDT_ADDR_CONTROL);
    assign wr_perl   = wr && (address == WDT_ADDR_PERIODL) && !lock;
    assign wr_perh   = wr && (address == WDT_ADDR_PERIODH) && !lock;
    assign wr_snap   = wr && (address == WDT_ADDR_SNAPL);
    assign wr_kick   = wr && (address == WDT_ADDR_KICK) && (writedata == KICK_KEY);

    // START wins over STOP in the same write; a lock suppresses STOP entirely.
    logic start, stop_eff;
    assign start    = wr_ctrl & writedata[WDT_CTRL_START];
    assign stop_eff = wr_ctrl & writedata[WDT_CTRL_STOP] & ~start & ~lock;

    // A pending kick or period reload pre-empts the zero-crossing, so no expire that cycle.
    logic running, rst_exit, reload_req, expire, cnt_load;
    assign running    = (state_q == ST_RUN) || (state_q == ST_WARN);
    assign rst_exit   = (state_q == ST_RST) && (rst_cnt_q == '0);
    assign reload_req = force_q | kick_q;
    assign expire     = running & cnt_zero & ~reload_req;
    assign cnt_load   = reload_req | (running & cnt_zero) | rst_exit;

`ifdef WDT_LOCK_EN
    logic lock_q;
    // Sticky lock armed by any accepted START; only reset_n clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q <= 1'b0;
        end else if (start && (state_q != ST_RST)) begin
            lock_q <= 1'b1;
        end
    end
    assign lock = lock_q;
`else
    assign lock = 1'b0;
`endif

    wdt_down_counter #(
        .CNT_W   (CNT_W),
        .RST_VAL (RST_VAL)
    ) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (cnt_load),
        .load_val_i (period_q),
        .en_i       (running),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    // Software-visible registers and the one-cycle reload requests they raise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ito_q    <= 1'b0;
            period_q <= RST_VAL;
            snap_q   <= '0;
            force_q  <= 1'b0;
            kick_q   <= 1'b0;
        end else begin
            force_q <= wr_perl | wr_perh;
            kick_q  <= wr_kick;
            if (wr_ctrl) ito_q <= writedata[WDT_CTRL_ITO];
            if (wr_perl) period_q[15:0] <= writedata;
            if (wr_perh) period_q[CNT_W-1:16] <= writedata[CNT_W-17:0];
            if (wr_snap) snap_q <= cnt;
        end
    end

    // Watchdog FSM with registered TO and resetrequest.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            to_q           <= 1'b0;
            resetrequest_q <= 1'b0;
            rst_cnt_q      <= '0;
        end else begin
            // Clearing first lets a simultaneous first expiry re-set TO below.
            if (wr_status) to_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (expire) begin
                        state_q <= ST_WARN;
                        to_q    <= 1'b1;
                    end else if (stop_eff) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WARN: begin
                    if (expire) begin
                        state_q        <= ST_RST;
                        resetrequest_q <= 1'b1;
                        rst_cnt_q      <= RC_W'(RST_CYCLES - 1);
                    end else if (stop_eff) begin
                        state_q <= ST_IDLE;
                    end else if (wr_status) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RST: begin
                    if (rst_cnt_q == '0) begin
                        state_q        <= ST_IDLE;
                        resetrequest_q <= 1'b0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Read mux; upper PERIOD/SNAP bits beyond CNT_W read as zero.
    logic [31:0] period_ext, snap_ext;
    assign period_ext = 32'(period_q);
    assign snap_ext   = 32'(snap_q);

    always_comb begin
        readdata_d = '0;
        case (address)
            WDT_ADDR_STATUS:  readdata_d = {13'b0, lock, running, to_q};
            WDT_ADDR_CONTROL: readdata_d = {15'b0, ito_q};
            WDT_ADDR_PERIODL: readdata_d = period_ext[15:0];
            WDT_ADDR_PERIODH: readdata_d = period_ext[31:16];
            WDT_ADDR_SNAPL:   readdata_d = snap_ext[15:0];
            WDT_ADDR_SNAPH:   readdata_d = snap_ext[31:16];
            default:          readdata_d = '0;
        endcase
    end

    // Registered read data, updated only on a read access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else if (rd) begin
            readdata_q <= readdata_d;
        end
    end

    assign readdata     = readdata_q;
    assign irq          = to_q & ito_q;
    assign resetrequest = resetrequest_q;

endmodule

// File: tb/tb_wdt_timer_param.sv
// Purpose: directed table plus timed sequences for the watchdog, built with CNT_W=17.
// Latency: n/a.
// Backpressure: n/a.
module tb_wdt_timer_param;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        irq;
    logic        resetrequest;

    int total = 0;
    int bad   = 0;

`ifdef WDT_LOCK_EN
    localparam logic LOCK_ON = 1'b1;
`else
    localparam logic LOCK_ON = 1'b0;
`endif

    wdt_timer_param #(
        .CNT_W        (17),
        .RESET_PERIOD (32'h004C_4B3F),
        .RST_CYCLES   (4),
        .KICK_KEY     (16'hA5C3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .irq          (irq),
        .resetrequest (resetrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [0:NV-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(posedge clk); #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic do_reset();
        chipselect = 1'b0; write_n = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Edges (1-based, after the call) until irq first reads 1; 0 if never.
    task automatic first_irq(input int limit, output int first);
        first = 0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (irq && first == 0) first = i;
        end
    endtask

    initial begin
        logic [15:0] d;
        int first, high;

        tbl[0]  = '{1'b0, 3'd0, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 3'd1, 16'h0000, 16'h0000};
        tbl[2]  = '{1'b0, 3'd2, 16'h0000, 16'h4B3F};
        tbl[3]  = '{1'b0, 3'd3, 16'h0000, 16'h0000};
        tbl[4]  = '{1'b0, 3'd4, 16'h0000, 16'h0000};
        tbl[5]  = '{1'b0, 3'd5, 16'h0000, 16'h0000};
        tbl[6]  = '{1'b0, 3'd6, 16'h0000, 16'h0000};
        tbl[7]  = '{1'b0, 3'd7, 16'h0000, 16'h0000};
        tbl[8]  = '{1'b1, 3'd4, 16'h1234, 16'h0000};
        tbl[9]  = '{1'b0, 3'd4, 16'h0000, 16'h4B3F};
        tbl[10] = '{1'b1, 3'd3, 16'hFFFF, 16'h0000};
        tbl[11] = '{1'b0, 3'd3, 16'h0000, 16'h0001};
        tbl[12] = '{1'b1, 3'd3, 16'h0000, 16'h0000};
        tbl[13] = '{1'b1, 3'd2, 16'h000A, 16'h0000};
        tbl[14] = '{1'b0, 3'd2, 16'h0000, 16'h000A};
        tbl[15] = '{1'b1, 3'd1, 16'h0001, 16'h0000};
        tbl[16] = '{1'b0, 3'd1, 16'h0000, 16'h0001};
        tbl[17] = '{1'b1, 3'd6, 16'hA5C3, 16'h0000};
        tbl[18] = '{1'b0, 3'd6, 16'h0000, 16'h0000};
        tbl[19] = '{1'b0, 3'd0, 16'h0000, 16'h0000};

        // Reset state
        do_reset();
        chk("rst_readdata", 32'(readdata), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_resetrequest", 32'(resetrequest), 32'h0);

        // Register table; leaves period=10, ITO=1, IDLE
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].wr) begin
                wr(tbl[i].addr, tbl[i].data);
            end else begin
                rd(tbl[i].addr, d);
                chk($sformatf("tbl%0d_addr%0d", i, tbl[i].addr), 32'(d), 32'(tbl[i].exp));
            end
        end

        // Basic expiry: period 10 -> TO visible 11 edges after START
        wr(3'd1, 16'h0005);
        first_irq(30, first);
        chk("basic_expire_edge", 32'(first), 32'd11);
        do_reset();
        wr(3'd2, 16'h000A);
        wr(3'd1, 16'h0005);
        repeat (10) @(posedge clk);
        #1;
        chk("basic_irq_before", 32'(irq), 32'h0);
        @(posedge clk); #1;
        chk("basic_irq_set", 32'(irq), 32'h1);
        wr(3'd0, 16'h0000);
        chk("basic_irq_cleared", 32'(irq), 32'h0);
        rd(3'd0, d);
        chk("basic_status_run", 32'(d), {29'b0, LOCK_ON, 2'b10});

        // Two-stage reset: period 5, no service
        do_reset();
        wr(3'd2, 16'h0005);
        wr(3'd1, 16'h0004);
        first = 0; high = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (resetrequest) begin
                if (first == 0) first = i;
                high++;
            end
        end
        chk("rr_first_edge", 32'(first), 32'd12);
        chk("rr_high_cycles", 32'(high), 32'd4);
        rd(3'd0, d);
        chk("rr_status_idle", 32'(d[1:0]), 32'h1);

        // reset_n asserted mid-RST
        do_reset();
        wr(3'd2, 16'h0005);
        wr(3'd1, 16'h0004);
        repeat (13) @(posedge clk);
        #1;
        chk("midrst_rr_high", 32'(resetrequest), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_rr_async_low", 32'(resetrequest), 32'h0);
        @(posedge clk); #1 reset_n = 1'b1;
        rd(3'd0, d);
        chk("midrst_status", 32'(d), 32'h0);

        // Kick every 15 clocks keeps TO clear; wrong key does not reload
        do_reset();
        wr(3'd2, 16'h0014);
        wr(3'd1, 16'h0005);
        for (int k = 0; k < 6; k++) begin
            wr(3'd6, 16'hA5C3);
            if (k < 5) repeat (14) @(posedge clk);
        end
        #1;
        chk("kick_no_irq", 32'(irq), 32'h0);
        wr(3'd6, 16'h1234);
        first_irq(40, first);
        chk("badkey_expire_edge", 32'(first), 32'd21);

        // Kick landing on the counter=0 cycle suppresses expire
        do_reset();
        wr(3'd2, 16'h0005);
        wr(3'd1, 16'h0005);
        repeat (4) @(posedge clk);
        #1;
        wr(3'd6, 16'hA5C3);
        repeat (2) @(posedge clk);
        #1;
        chk("kick_at_zero_no_irq", 32'(irq), 32'h0);

        // STATUS write on the expire cycle in RUN: TO still set
        do_reset();
        wr(3'd2, 16'h0005);
        wr(3'd1, 16'h0005);
        repeat (5) @(posedge clk);
        #1;
        wr(3'd0, 16'h0000);
        chk("status_vs_expire_irq", 32'(irq), 32'h1);

        // START+STOP in one write: START wins
        do_reset();
        wr(3'd1, 16'h000C);
        rd(3'd0, d);
        chk("start_stop_run", 32'(d[1]), 32'h1);

        // Snapshot of a 17-bit period
        do_reset();
        wr(3'd2, 16'h0005);
        wr(3'd3, 16'h0001);
        @(posedge clk); #1;
        wr(3'd4, 16'h0000);
        rd(3'd5, d);
        chk("snaph", 32'(d), 32'h1);
        rd(3'd4, d);
        chk("snapl", 32'(d), 32'h5);

        // STOP / period write after START (lock-dependent)
        do_reset();
        wr(3'd2, 16'h0100);
        wr(3'd1, 16'h0004);
        wr(3'd1, 16'h0008);
        wr(3'd2, 16'h0033);
        rd(3'd0, d);
        chk("lock_status", 32'(d), LOCK_ON ? 32'h6 : 32'h0);
        rd(3'd2, d);
        chk("lock_periodl", 32'(d), LOCK_ON ? 32'h0100 : 32'h0033);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wdt_timer_param.md
# wdt_timer_param

Parametrised Avalon-MM watchdog timer, successor to the fixed-period single-stage watchdog in the SOPC peripheral set. It adds a software-writable period of configurable width, a keyed kick register, a counter snapshot, a stop control, and two-stage expiry. The first expiry raises an interrupt; a second expiry without service asserts `resetrequest` for a programmable number of cycles. It sits on the system interconnect as a 16-bit slave beside the other SOPC timers.

## Interface
- `CNT_W`, 32: counter/period width, legal 17..32.
- `RESET_PERIOD`, 32'h004C_4B3F: period register and counter reset value, truncated to `CNT_W`.
- `RST_CYCLES`, 4: `resetrequest` pulse length in clocks, ≥1.
- `KICK_KEY`, 16'hA5C3: value that must be written to KICK to reload.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `address` in 3: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 16: write data.
- `readdata` out 16: registered read data, reset 0.
- `irq` out 1: `TO & ITO`, reset 0.
- `resetrequest` out 1: system reset request, reset 0.

## Operation
- Write strobe = `chipselect & ~write_n`; reads are side-effect free.
- Register map:
  - 0 STATUS: r `{14'b0, RUN, TO}`; any write clears TO.
  - 1 CONTROL: bit0 ITO (stored); bit2 START and bit3 STOP are strobes; reads return `{15'b0, ITO}`.
  - 2 PERIODL: period[15:0].
  - 3 PERIODH: period[CNT_W-1:16], unused upper bits read 0.
  - 4 SNAPL: write any value copies the counter into snap; read snap[15:0].
  - 5 SNAPH: read snap[CNT_W-1:16].
  - 6 KICK: write `KICK_KEY` → reload; other values are ignored. Reads return 0.
  - 7: reserved, reads 0.
- Counter: `CNT_W`-bit down-counter, reset `RESET_PERIOD`. When running it decrements; at 0 it reloads `period` and fires `expire` (one cycle).
- Force reload: a PERIODL/PERIODH write stores the value on that edge. The counter loads the new period on the following edge, whether running or not.
- State machine (`IDLE`, `RUN`, `WARN`, `RST`), reset `IDLE`:
  - `IDLE`: counter holds; START → `RUN`.
  - `RUN`: `expire` → `WARN`, TO set. STOP → `IDLE`.
  - `WARN`: a STATUS write → `RUN`. `expire` → `RST`. STOP → `IDLE`, TO retained.
  - `RST`: `resetrequest`=1 for exactly `RST_CYCLES` clocks, then `IDLE`, counter reloaded. START and STOP are ignored in `RST`.
- RUN = state ∈ {`RUN`, `WARN`}.
- Simultaneous events:
  - START+STOP in one write → START wins.
  - Kick or force reload on the same cycle as counter=0 → reload wins, no `expire`.
  - STATUS write on the same cycle as `expire` in `RUN` → `expire` wins (TO stays set).
  - STATUS write on the same cycle as `expire` in `WARN` → `RST`.
- `reset_n` is asserted mid-`RST`: `resetrequest` deasserts asynchronously and all registers return to reset values.

## Timing
- Read latency 1 clock: `readdata` is valid the cycle after the address is presented with `chipselect`.
- Write takes effect on the strobe edge; counter effects of START, kick and force reload appear one clock later.
- Period P means `expire` every P+1 clocks while running.
- Time from `expire` in `WARN` to `resetrequest` high: 1 clock.
- `irq` is combinational from registered TO/ITO, with no added latency.

## Configuration
- `WDT_LOCK_EN` defined:
  - START sets sticky LOCK, cleared only by `reset_n`.
  - While LOCK is set, STOP and PERIODL/PERIODH writes are ignored.
  - STATUS bit2 reads LOCK.
- `WDT_LOCK_EN` undefined: no LOCK flop, STATUS bit2 reads 0, STOP and period writes are always honoured.

## Structure
- Package `wdt_pkg`: register address constants (`WDT_ADDR_STATUS`..`WDT_ADDR_KICK`), control bit indices, and the state enum `wdt_state_t`.
- One sub-module, `wdt_down_counter`: parametrised `CNT_W` counter with load, enable and zero flag.
- Register decode, FSM and read mux live in the top.

## Test plan
- Reset: readdata=0, irq=0, resetrequest=0, STATUS reads `{RUN=0, TO=0}`; counter idle at `RESET_PERIOD`.
- Basic expiry: period=10, ITO=1, START → first `expire` 11 clocks after START takes effect, TO=1, irq=1; STATUS write → irq=0, state `RUN`.
- Two-stage reset: period=5, START, no service → `resetrequest` high for exactly 4 clocks, then state `IDLE`, RUN=0.
- Kick: period=20; write 16'hA5C3 every 15 clocks → TO never set. Write 16'h1234 → no reload, `expire` at 21.
- Simultaneous: kick on the counter=0 cycle → no TO. START+STOP in one write → RUN=1. PERIODH=16'h0001 with CNT_W=17 → snapshot reads SNAPH=1.
- With `WDT_LOCK_EN`: START, then STOP and PERIODL writes → RUN stays 1, period unchanged, STATUS bit2=1.
